// File: rtl/rom_stream_loader_if.sv
// Byte-stream input handshake plus ROM write strobes and status for rom_stream_loader.
interface rom_stream_loader_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output in_valid, in_data,
    input  in_ready, wr_en, wr_addr, wr_data, busy, done, err
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, wr_en, wr_addr, wr_data, busy, done, err
  );
endinterface

// File: rtl/rom_stream_loader.sv
// Frame parser (SYNC, ADDR, LEN, DATA.., CHK) feeding ROM byte writes one cycle after each accepted data byte.
// Backpressure: in_ready drops only for the single RESULT cycle; in_valid low stalls in place.
module rom_stream_loader #(
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter logic [15:0] TIMEOUT   = 16'd50000
) (
  input logic          clk,
  input logic          rst_n,
  rom_stream_loader_if.slave bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ADDR   = 3'd1;
  localparam logic [2:0] S_LEN    = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_CHK    = 3'd4;
  localparam logic [2:0] S_RESULT = 3'd5;

  logic [2:0]  state;
  logic [7:0]  addr_q;
  logic [8:0]  cnt_q;
  logic [7:0]  sum_q;
  logic [15:0] to_cnt;
  logic        wr_en_q;
  logic [7:0]  wr_addr_q;
  logic [7:0]  wr_data_q;
  logic        done_q;
  logic        err_q;
  logic        accept;
  logic        in_frame;

  assign bus.in_ready = (state != S_RESULT);
  assign bus.busy     = (state != S_IDLE);
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;

  assign accept   = bus.in_valid && bus.in_ready;
  assign in_frame = (state == S_ADDR) || (state == S_LEN) ||
                    (state == S_DATA) || (state == S_CHK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      addr_q    <= 8'h00;
      cnt_q     <= 9'd0;
      sum_q     <= 8'h00;
      to_cnt    <= 16'd0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= 8'h00;
      wr_data_q <= 8'h00;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;

      // Idle timer only runs mid-frame; any accepted byte restarts it.
      if (in_frame && !accept) begin
        if (TIMEOUT != 16'd0) begin
          to_cnt <= to_cnt + 16'd1;
        end
      end else begin
        to_cnt <= 16'd0;
      end

      case (state)
        S_IDLE: begin
          if (accept && bus.in_data == SYNC_BYTE) begin
            state <= S_ADDR;
            err_q <= 1'b0;
          end
        end
        S_ADDR: begin
          if (accept) begin
            addr_q <= bus.in_data;
            sum_q  <= bus.in_data;
            state  <= S_LEN;
          end
        end
        S_LEN: begin
          if (accept) begin
            cnt_q <= (bus.in_data == 8'h00) ? 9'd256 : {1'b0, bus.in_data};
            sum_q <= sum_q + bus.in_data;
            state <= S_DATA;
          end
        end
        S_DATA: begin
          if (accept) begin
            sum_q     <= sum_q + bus.in_data;
            wr_en_q   <= 1'b1;
            wr_addr_q <= addr_q;
            wr_data_q <= bus.in_data;
            addr_q    <= addr_q + 8'h01;
            cnt_q     <= cnt_q - 9'd1;
            if (cnt_q == 9'd1) begin
              state <= S_CHK;
            end
          end
        end
        S_CHK: begin
          // done/err are registered here so they are visible during RESULT.
          if (accept) begin
            done_q <= 1'b1;
            err_q  <= (bus.in_data != sum_q);
            state  <= S_RESULT;
          end
        end
        S_RESULT: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase

      if (in_frame && !accept && TIMEOUT != 16'd0 && to_cnt == TIMEOUT - 16'd1) begin
        state  <= S_IDLE;
        err_q  <= 1'b1;
        to_cnt <= 16'd0;
      end
    end
  end

endmodule

// File: tb/tb_rom_stream_loader.sv
// Directed vector bench for rom_stream_loader, built with an 8-cycle timeout.
module tb_rom_stream_loader;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  rom_stream_loader_if bus ();

  rom_stream_loader #(
    .SYNC_BYTE (8'hA5),
    .TIMEOUT   (16'd8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [7:0]  din;
    logic [20:0] exp;
  } vec_t;

  vec_t rows[$];

  // Expected packing: {in_ready, wr_en, wr_addr, wr_data, busy, done, err}.
  function automatic logic [20:0] ex(input logic rdy, input logic we, input logic [7:0] wa,
                                     input logic [7:0] wd, input logic bsy, input logic dn,
                                     input logic er);
    return {rdy, we, wa, wd, bsy, dn, er};
  endfunction

  function automatic void add(input logic v, input logic [7:0] d, input logic rdy, input logic we,
                              input logic [7:0] wa, input logic [7:0] wd, input logic bsy,
                              input logic dn, input logic er);
    vec_t r;
    r.vld = v;
    r.din = d;
    r.exp = ex(rdy, we, wa, wd, bsy, dn, er);
    rows.push_back(r);
  endfunction

  task automatic check(input logic [20:0] exp, input string name);
    logic [20:0] act;
    act = {bus.in_ready, bus.wr_en, bus.wr_addr, bus.wr_data, bus.busy, bus.done, bus.err};
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got rdy=%b we=%b addr=%h data=%h busy=%b done=%b err=%b, want rdy=%b we=%b addr=%h data=%h busy=%b done=%b err=%b",
               name, act[20], act[19], act[18:11], act[10:3], act[2], act[1], act[0],
               exp[20], exp[19], exp[18:11], exp[10:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic [20:0] exp, input string name);
    @(negedge clk);
    bus.in_valid = v;
    bus.in_data  = d;
    @(posedge clk);
    #1;
    check(exp, name);
  endtask

  initial begin
    n_pass       = 0;
    n_total      = 0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    // Basic frame; the A5 offered during RESULT must be refused.
    add(1, 8'hA5, 1, 0, 8'h00, 8'h00, 1, 0, 0);
    add(1, 8'h10, 1, 0, 8'h00, 8'h00, 1, 0, 0);
    add(1, 8'h03, 1, 0, 8'h00, 8'h00, 1, 0, 0);
    add(1, 8'h11, 1, 1, 8'h10, 8'h11, 1, 0, 0);
    add(1, 8'h22, 1, 1, 8'h11, 8'h22, 1, 0, 0);
    add(1, 8'h33, 1, 1, 8'h12, 8'h33, 1, 0, 0);
    add(1, 8'h79, 0, 0, 8'h12, 8'h33, 1, 1, 0);
    add(1, 8'hA5, 1, 0, 8'h12, 8'h33, 0, 0, 0);
    // Address wrap with 3-cycle stalls between data bytes.
    add(1, 8'hA5, 1, 0, 8'h12, 8'h33, 1, 0, 0);
    add(1, 8'hFE, 1, 0, 8'h12, 8'h33, 1, 0, 0);
    add(1, 8'h03, 1, 0, 8'h12, 8'h33, 1, 0, 0);
    add(1, 8'h01, 1, 1, 8'hFE, 8'h01, 1, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 8'hEE, 1, 0, 8'hFE, 8'h01, 1, 0, 0);
    add(1, 8'h02, 1, 1, 8'hFF, 8'h02, 1, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 8'hEE, 1, 0, 8'hFF, 8'h02, 1, 0, 0);
    add(1, 8'h03, 1, 1, 8'h00, 8'h03, 1, 0, 0);
    add(1, 8'h07, 0, 0, 8'h00, 8'h03, 1, 1, 0);
    add(0, 8'h00, 1, 0, 8'h00, 8'h03, 0, 0, 0);
    // Bad checksum, garbage keeps err, good frame clears it.
    add(1, 8'hA5, 1, 0, 8'h00, 8'h03, 1, 0, 0);
    add(1, 8'h10, 1, 0, 8'h00, 8'h03, 1, 0, 0);
    add(1, 8'h03, 1, 0, 8'h00, 8'h03, 1, 0, 0);
    add(1, 8'h11, 1, 1, 8'h10, 8'h11, 1, 0, 0);
    add(1, 8'h22, 1, 1, 8'h11, 8'h22, 1, 0, 0);
    add(1, 8'h33, 1, 1, 8'h12, 8'h33, 1, 0, 0);
    add(1, 8'h78, 0, 0, 8'h12, 8'h33, 1, 1, 1);
    add(0, 8'h00, 1, 0, 8'h12, 8'h33, 0, 0, 1);
    add(1, 8'h00, 1, 0, 8'h12, 8'h33, 0, 0, 1);
    add(1, 8'hFF, 1, 0, 8'h12, 8'h33, 0, 0, 1);
    add(1, 8'h5A, 1, 0, 8'h12, 8'h33, 0, 0, 1);
    add(1, 8'h12, 1, 0, 8'h12, 8'h33, 0, 0, 1);
    add(1, 8'h34, 1, 0, 8'h12, 8'h33, 0, 0, 1);
    add(1, 8'hA5, 1, 0, 8'h12, 8'h33, 1, 0, 0);
    add(1, 8'h10, 1, 0, 8'h12, 8'h33, 1, 0, 0);
    add(1, 8'h03, 1, 0, 8'h12, 8'h33, 1, 0, 0);
    add(1, 8'h11, 1, 1, 8'h10, 8'h11, 1, 0, 0);
    add(1, 8'h22, 1, 1, 8'h11, 8'h22, 1, 0, 0);
    add(1, 8'h33, 1, 1, 8'h12, 8'h33, 1, 0, 0);
    add(1, 8'h79, 0, 0, 8'h12, 8'h33, 1, 1, 0);
    add(0, 8'h00, 1, 0, 8'h12, 8'h33, 0, 0, 0);
    // IDLE garbage, then a frame that stalls after ADDR until the timeout fires.
    add(1, 8'h00, 1, 0, 8'h12, 8'h33, 0, 0, 0);
    add(1, 8'hFF, 1, 0, 8'h12, 8'h33, 0, 0, 0);
    add(1, 8'h5A, 1, 0, 8'h12, 8'h33, 0, 0, 0);
    add(1, 8'hA5, 1, 0, 8'h12, 8'h33, 1, 0, 0);
    add(1, 8'h20, 1, 0, 8'h12, 8'h33, 1, 0, 0);
    for (int i = 0; i < 7; i++) add(0, 8'h00, 1, 0, 8'h12, 8'h33, 1, 0, 0);
    add(0, 8'h00, 1, 0, 8'h12, 8'h33, 0, 0, 1);
    add(0, 8'h00, 1, 0, 8'h12, 8'h33, 0, 0, 1);

    repeat (2) @(posedge clk);
    #1;
    check(ex(1, 0, 8'h00, 8'h00, 0, 0, 0), "reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < rows.size(); i++) begin
      step(rows[i].vld, rows[i].din, rows[i].exp, $sformatf("vec%0d", i));
    end

    // Full 256-byte frame: LEN=00, data 00..FF at ADDR 00, CHK = 0x7F80 mod 256 = 0x80.
    step(1, 8'hA5, ex(1, 0, 8'h12, 8'h33, 1, 0, 0), "full_sync");
    step(1, 8'h00, ex(1, 0, 8'h12, 8'h33, 1, 0, 0), "full_addr");
    step(1, 8'h00, ex(1, 0, 8'h12, 8'h33, 1, 0, 0), "full_len");
    for (int i = 0; i < 256; i++) begin
      logic [7:0] b;
      b = i[7:0];
      step(1, b, ex(1, 1, b, b, 1, 0, 0), $sformatf("full_d%0d", i));
    end
    step(1, 8'h80, ex(0, 0, 8'hFF, 8'hFF, 1, 1, 0), "full_chk");
    step(0, 8'h00, ex(1, 0, 8'hFF, 8'hFF, 0, 0, 0), "full_idle");

    // Asynchronous reset during DATA after two writes.
    step(1, 8'hA5, ex(1, 0, 8'hFF, 8'hFF, 1, 0, 0), "rst_sync");
    step(1, 8'h40, ex(1, 0, 8'hFF, 8'hFF, 1, 0, 0), "rst_addr");
    step(1, 8'h05, ex(1, 0, 8'hFF, 8'hFF, 1, 0, 0), "rst_len");
    step(1, 8'hAA, ex(1, 1, 8'h40, 8'hAA, 1, 0, 0), "rst_d0");
    step(1, 8'hBB, ex(1, 1, 8'h41, 8'hBB, 1, 0, 0), "rst_d1");
    #2;
    rst_n = 1'b0;
    #1;
    check(ex(1, 0, 8'h00, 8'h00, 0, 0, 0), "rst_async");
    step(1, 8'hCC, ex(1, 0, 8'h00, 8'h00, 0, 0, 0), "rst_held");
    @(negedge clk);
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    step(1, 8'hA5, ex(1, 0, 8'h00, 8'h00, 1, 0, 0), "post_sync");
    step(1, 8'h40, ex(1, 0, 8'h00, 8'h00, 1, 0, 0), "post_addr");
    step(1, 8'h02, ex(1, 0, 8'h00, 8'h00, 1, 0, 0), "post_len");
    step(1, 8'h01, ex(1, 1, 8'h40, 8'h01, 1, 0, 0), "post_d0");
    step(1, 8'h02, ex(1, 1, 8'h41, 8'h02, 1, 0, 0), "post_d1");
    step(1, 8'h45, ex(0, 0, 8'h41, 8'h02, 1, 1, 0), "post_chk");
    step(0, 8'h00, ex(1, 0, 8'h41, 8'h02, 0, 0, 0), "post_idle");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
